// File: rtl/lsu_axi_master.sv
// Load/store unit bus front-end: turns one core request into one AXI4-Lite read or write,
// steering store bytes onto the lanes and extracting/extending load data.
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AWW  = 3'd3,
        ST_B    = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    state_t                state_r, state_nx_s;
    logic [ADDR_W-1:0]     addr_r;
    logic [DATA_W-1:0]     wdata_r;
    logic [DATA_W/8-1:0]   strb_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic                  aw_pend_r;
    logic                  w_pend_r;
    logic [DATA_W-1:0]     rdata_r;
    logic                  err_r;
    logic                  misalign_s;

    // SLVERR/DECERR have bit 1 set; OKAY and EXOKAY are both success.
    function automatic logic axi_resp_err(input logic [1:0] resp);
        case (resp)
            2'b00, 2'b01: axi_resp_err = 1'b0;
            default:      axi_resp_err = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] raw,
                                                       input logic [1:0] off,
                                                       input logic [1:0] size,
                                                       input logic uns);
        logic [DATA_W-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    load_extract = uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}
                                        : {{(DATA_W-8){sh[7]}}, sh[7:0]};
            2'd1:    load_extract = uns ? {{(DATA_W-16){1'b0}}, sh[15:0]}
                                        : {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    function automatic logic [DATA_W/8-1:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [DATA_W/8-1:0] base;
        case (size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        store_strb = base << off;
    endfunction

    // Natural-alignment check of the incoming request.
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            2'd0:    misalign_s = 1'b0;
            2'd1:    misalign_s = req_addr[0];
            2'd2:    misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; AW and W may complete in either order or together.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misalign_s)   state_nx_s = ST_RESP;
                    else if (req_wen) state_nx_s = ST_AWW;
                    else              state_nx_s = ST_AR;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_AR:   if (m_arready) state_nx_s = ST_R;    else state_nx_s = ST_AR;
            ST_R:    if (m_rvalid)  state_nx_s = ST_RESP; else state_nx_s = ST_R;
            ST_AWW: begin
                if ((!aw_pend_r || m_awready) && (!w_pend_r || m_wready)) state_nx_s = ST_B;
                else                                                      state_nx_s = ST_AWW;
            end
            ST_B:    if (m_bvalid)   state_nx_s = ST_RESP; else state_nx_s = ST_B;
            ST_RESP: if (resp_ready) state_nx_s = ST_IDLE; else state_nx_s = ST_RESP;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Request capture, write-channel tracking and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            strb_r     <= {(DATA_W/8){1'b0}};
            size_r     <= 2'd0;
            unsigned_r <= 1'b0;
            aw_pend_r  <= 1'b0;
            w_pend_r   <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_r     <= req_addr;
                        wdata_r    <= req_wdata << {req_addr[1:0], 3'b000};
                        strb_r     <= store_strb(req_size, req_addr[1:0]);
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        aw_pend_r  <= req_wen & ~misalign_s;
                        w_pend_r   <= req_wen & ~misalign_s;
                        rdata_r    <= {DATA_W{1'b0}};
                        err_r      <= misalign_s;
                    end
                end
                ST_R: begin
                    if (m_rvalid) begin
                        err_r   <= axi_resp_err(m_rresp);
                        rdata_r <= axi_resp_err(m_rresp) ? {DATA_W{1'b0}}
                                   : load_extract(m_rdata, addr_r[1:0], size_r, unsigned_r);
                    end
                end
                ST_AWW: begin
                    if (aw_pend_r && m_awready) aw_pend_r <= 1'b0;
                    if (w_pend_r && m_wready)   w_pend_r  <= 1'b0;
                end
                ST_B: begin
                    if (m_bvalid) err_r <= axi_resp_err(m_bresp);
                end
                default: begin
                end
            endcase
        end
    end

    // Reset holds state at IDLE, so ready is additionally qualified by rst_n.
    assign req_ready  = (state_r == ST_IDLE) & rst_n;
    assign resp_valid = (state_r == ST_RESP);
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r & (state_r == ST_RESP);
    assign m_araddr   = addr_r;
    assign m_arvalid  = (state_r == ST_AR);
    assign m_rready   = (state_r == ST_R);
    assign m_awaddr   = addr_r;
    assign m_awvalid  = aw_pend_r;
    assign m_wdata    = wdata_r;
    assign m_wstrb    = strb_r;
    assign m_wvalid   = w_pend_r;
    assign m_bready   = (state_r == ST_B);

endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master: directed requests push expected responses,
// a negedge monitor pops and compares them and tallies AXI handshakes.
module tb_lsu_axi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        resp_valid, resp_ready = 1'b1, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic        m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
    logic [31:0] m_rdata = 32'h0;
    logic [1:0]  m_rresp = 2'b00, m_bresp = 2'b00;
    logic        m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0;
    logic [3:0]  m_wstrb;
    logic        m_bvalid = 1'b0, m_bready;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        string       name;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration
    int          ar_wait = 0, aw_wait = 0, w_wait = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    logic        r_force = 1'b0;

    // monitor tallies
    int          n_ar_hs = 0, n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_r_hs = 0;
    int          n_arv = 0, n_awv = 0, n_wv = 0, n_ar_unstable = 0;
    logic [31:0] last_araddr = 32'h0, last_wdata = 32'h0;
    logic [3:0]  last_wstrb = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // AXI slave: readies after a configurable number of valid cycles, R/B answered at once.
    initial begin
        int ar_cnt, aw_cnt, w_cnt;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (m_arvalid) begin m_arready = (ar_cnt == ar_wait); ar_cnt++; end
            else begin m_arready = 1'b0; ar_cnt = 0; end
            if (m_awvalid) begin m_awready = (aw_cnt == aw_wait); aw_cnt++; end
            else begin m_awready = 1'b0; aw_cnt = 0; end
            if (m_wvalid) begin m_wready = (w_cnt == w_wait); w_cnt++; end
            else begin m_wready = 1'b0; w_cnt = 0; end
            m_rvalid = r_force | m_rready;
            m_rdata  = rdata_cfg;
            m_rresp  = rresp_cfg;
            m_bvalid = m_bready;
            m_bresp  = bresp_cfg;
        end
    end

    // Monitor: bus tallies plus scoreboard comparison of every response handshake.
    initial begin
        logic        p_arvalid, p_arready;
        logic [31:0] p_araddr;
        exp_t        e;
        p_arvalid = 1'b0; p_arready = 1'b0; p_araddr = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_arvalid = 1'b0;
            end else begin
                if (m_arvalid) n_arv++;
                if (m_awvalid) n_awv++;
                if (m_wvalid)  n_wv++;
                if (m_arvalid && m_arready) begin n_ar_hs++; last_araddr = m_araddr; end
                if (m_awvalid && m_awready) n_aw_hs++;
                if (m_wvalid && m_wready) begin n_w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb; end
                if (m_bvalid && m_bready) n_b_hs++;
                if (m_rvalid && m_rready) n_r_hs++;
                if (p_arvalid && !p_arready && (!m_arvalid || m_araddr != p_araddr)) n_ar_unstable++;
                p_arvalid = m_arvalid; p_arready = m_arready; p_araddr = m_araddr;
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, expected none", resp_rdata, resp_err);
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, "_rdata"}, resp_rdata, e.rd);
                        chk({e.name, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
                    end
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin n_cmp++; n_bad++; $display("FAIL %s_ready_timeout: got req_ready 0, expected 1", name); end
    endtask

    task automatic run(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input logic hs, input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                       input string name);
        exp_t e;
        int lat, ar0, aw0, w0, b0, arv0, awv0, wv0, un0;
        e.rd = exp_rd; e.err = exp_err; e.name = name;
        ar0 = n_ar_hs; aw0 = n_aw_hs; w0 = n_w_hs; b0 = n_b_hs;
        arv0 = n_arv; awv0 = n_awv; wv0 = n_wv; un0 = n_ar_unstable;
        wait_ready(name);
        exp_q.push_back(e);
        req_wen = wen; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 200);
        chk({name, "_latency"}, lat, exp_lat);
        @(posedge clk);
        #1;
        chk({name, "_ar_hs"}, n_ar_hs - ar0, (hs && !wen) ? 1 : 0);
        chk({name, "_aw_hs"}, n_aw_hs - aw0, (hs && wen) ? 1 : 0);
        chk({name, "_w_hs"},  n_w_hs - w0,   (hs && wen) ? 1 : 0);
        chk({name, "_b_hs"},  n_b_hs - b0,   (hs && wen) ? 1 : 0);
        chk({name, "_arvalid_cycles"}, n_arv - arv0, (hs && !wen) ? ar_wait + 1 : 0);
        chk({name, "_awvalid_cycles"}, n_awv - awv0, (hs && wen) ? aw_wait + 1 : 0);
        chk({name, "_wvalid_cycles"},  n_wv - wv0,   (hs && wen) ? w_wait + 1 : 0);
        chk({name, "_araddr_stable"}, n_ar_unstable - un0, 0);
        if (hs && wen) begin
            chk({name, "_wdata"}, last_wdata, exp_wdata);
            chk({name, "_wstrb"}, {28'h0, last_wstrb}, {28'h0, exp_strb});
        end
        if (hs && !wen) chk({name, "_araddr"}, last_araddr, addr);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_valids", {27'h0, m_arvalid, m_awvalid, m_wvalid, resp_valid, resp_err}, 32'h0);
        chk("rst_readies", {30'h0, m_rready, m_bready}, 32'h0);
        chk("rst_wstrb_wdata", {28'h0, m_wstrb} | m_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

        rdata_cfg = 32'h8012_3456;
        run(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lb_sext");
        run(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h0000_0080, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lbu");
        rdata_cfg = 32'h8001_7F00;
        run(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'hFFFF_8001, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lh_sext");
        run(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'h0000_8001, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lhu");
        run(1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 32'h0000_007F, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lb_pos");
        rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b01;
        run(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lw_exokay");
        rresp_cfg = 2'b00;

        run(1'b1, 32'h8000_0002, 32'hABCD_1234, 2'd1, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'h1234_0000, 4'b1100, "sh");
        run(1'b1, 32'h8000_0001, 32'hFFFF_FFA5, 2'd0, 1'b0, 32'h0, 1'b0, 3, 1'b1, 32'hFFFF_A500, 4'b0010, "sb");
        aw_wait = 0; w_wait = 3;
        run(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0, 1'b0, 6, 1'b1, 32'hCAFE_F00D, 4'b1111, "sw_aw_first");
        aw_wait = 2; w_wait = 0;
        run(1'b1, 32'h8000_0014, 32'h0102_0304, 2'd2, 1'b0, 32'h0, 1'b0, 5, 1'b1, 32'h0102_0304, 4'b1111, "sw_w_first");
        aw_wait = 0; w_wait = 0; bresp_cfg = 2'b10;
        run(1'b1, 32'h8000_0018, 32'h5555_AAAA, 2'd2, 1'b0, 32'h0, 1'b1, 3, 1'b1, 32'h5555_AAAA, 4'b1111, "sw_slverr");
        bresp_cfg = 2'b00;

        run(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, "lw_misaligned");
        run(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, "size3");
        run(1'b1, 32'h8000_0001, 32'h1234, 2'd1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 4'h0, "sh_misaligned");

        ar_wait = 5; rresp_cfg = 2'b10; rdata_cfg = 32'h1111_2222;
        run(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 8, 1'b1, 32'h0, 4'h0, "lw_stall_err");
        ar_wait = 0; rresp_cfg = 2'b00;

        // Reset while the DUT sits in R with rvalid already presented.
        wait_ready("lw_abort");
        req_wen = 1'b0; req_addr = 32'h8000_0008; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("abort_in_r", {30'h0, m_rready, m_rvalid}, 32'h3);
        rst_n = 1'b0;
        r_force = 1'b1;
        #1;
        chk("abort_rready", {31'h0, m_rready}, 32'h0);
        chk("abort_req_ready", {31'h0, req_ready}, 32'h0);
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_idle", {30'h0, req_ready, m_rready}, 32'h2);
        r_force = 1'b0;
        rdata_cfg = 32'h0BAD_F00D;
        run(1'b0, 32'h8000_0024, 32'h0, 2'd2, 1'b0, 32'h0BAD_F00D, 1'b0, 3, 1'b1, 32'h0, 4'h0, "lw_after_rst");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
